// File: rtl/sa_pkg.sv
// Shared types and constants for the systolic-array SRAM loader: FSM state
// encoding, default geometry and the job-shape legality check.
package sa_pkg;

  localparam int N_DEF      = 8;
  localparam int ADDR_W_DEF = 12;
  localparam int WORD_W     = N_DEF * 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_ROW,
    LOAD_COL,
    KICK,
    WAIT_ARR,
    FIN
  } state_t;

  // A bank image is legal when it is non-empty and fits the bank address space.
  function automatic logic words_ok(input logic [15:0] words, input int addr_w);
    return (words != 16'd0) && (32'(words) <= (32'd1 << addr_w));
  endfunction

endpackage

// File: rtl/sa_sram_loader_if.sv
// Word stream and dual-bank SRAM write port of the loader. The master modport
// is the stream producer / SRAM side, the slave modport is the loader.
interface sa_sram_loader_if
  import sa_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              in_valid;
  logic              in_ready;
  logic [N*8-1:0]    in_data;

  logic              wen_row_n;
  logic [ADDR_W-1:0] waddr_row;
  logic [N*8-1:0]    wdata_row;

  logic              wen_col_n;
  logic [ADDR_W-1:0] waddr_col;
  logic [N*8-1:0]    wdata_col;

  modport master (
    output in_valid, in_data,
    input  in_ready,
    input  wen_row_n, waddr_row, wdata_row,
    input  wen_col_n, waddr_col, wdata_col
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready,
    output wen_row_n, waddr_row, wdata_row,
    output wen_col_n, waddr_col, wdata_col
  );

endinterface

// File: rtl/sa_load_cnt.sv
// Clearable, enable-gated bank address counter with a terminal-count flag;
// shared by the row and column load phases.
module sa_load_cnt
  import sa_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [ADDR_W-1:0] last,
  output logic [ADDR_W-1:0] cnt,
  output logic              tc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + ADDR_W'(1);
    end
  end

  assign tc = (cnt == last);

endmodule

// File: rtl/sa_sram_loader.sv
// Loads row then column SRAM banks from a word stream, launches the array and
// waits for completion. SA_LOADER_CHECKSUM_EN adds an XOR checksum output.
module sa_sram_loader
  import sa_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic [7:0]       k_param,
  input  logic [7:0]       row_shape,
  input  logic [7:0]       col_shape,
  sa_sram_loader_if.slave  bus,
  output logic             start_all,
  input  logic             done_all,
  output logic             busy,
  output logic             job_done,
  output logic             job_err
`ifdef SA_LOADER_CHECKSUM_EN
  ,
  output logic [N*8-1:0]   checksum
`endif
);

  state_t            state, state_n;
  logic [15:0]       row_req, col_req, row_words, col_words;
  logic              shape_ok, err_q, xfer;
  logic              cnt_clr, cnt_tc;
  logic [ADDR_W-1:0] cnt, cnt_last;
  logic [N*8-1:0]    word_c;

  // Products are 16 bits wide so 255*255 reaches the range check untruncated.
  assign row_req  = 16'(row_shape) * 16'(k_param);
  assign col_req  = 16'(col_shape) * 16'(k_param);
  assign shape_ok = words_ok(row_req, ADDR_W) && words_ok(col_req, ADDR_W);
  assign xfer     = bus.in_valid && bus.in_ready;
  assign word_c   = bus.in_data;
  assign cnt_last = (state == LOAD_COL) ? ADDR_W'(col_words - 16'd1)
                                        : ADDR_W'(row_words - 16'd1);
  assign cnt_clr  = (state_n != state);

  sa_load_cnt #(.ADDR_W(ADDR_W)) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .en   (xfer),
    .last (cnt_last),
    .cnt  (cnt),
    .tc   (cnt_tc)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (load_start) state_n = shape_ok ? LOAD_ROW : FIN;
      LOAD_ROW: if (xfer && cnt_tc) state_n = LOAD_COL;
      LOAD_COL: if (xfer && cnt_tc) state_n = KICK;
      KICK:     state_n = WAIT_ARR;
      WAIT_ARR: if (done_all) state_n = FIN;
      FIN:      state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  // Control stage: state, handshake and status pulses all registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      row_words    <= '0;
      col_words    <= '0;
      err_q        <= 1'b0;
      bus.in_ready <= 1'b0;
      busy         <= 1'b0;
      start_all    <= 1'b0;
      job_done     <= 1'b0;
      job_err      <= 1'b0;
    end else begin
      state        <= state_n;
      bus.in_ready <= (state_n == LOAD_ROW) || (state_n == LOAD_COL);
      busy         <= (state_n != IDLE);
      start_all    <= (state == KICK);
      job_done     <= (state == FIN) && !err_q;
      job_err      <= (state == FIN) && err_q;
      if (state == IDLE && load_start) begin
        row_words <= row_req;
        col_words <= col_req;
        err_q     <= !shape_ok;
      end
    end
  end

  // Write stage: SRAM port driven one cycle after each accepted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.wen_row_n <= 1'b1;
      bus.waddr_row <= '0;
      bus.wdata_row <= '0;
      bus.wen_col_n <= 1'b1;
      bus.waddr_col <= '0;
      bus.wdata_col <= '0;
    end else begin
      bus.wen_row_n <= !(xfer && state == LOAD_ROW);
      bus.wen_col_n <= !(xfer && state == LOAD_COL);
      if (xfer && state == LOAD_ROW) begin
        bus.waddr_row <= cnt;
        bus.wdata_row <= word_c;
      end
      if (xfer && state == LOAD_COL) begin
        bus.waddr_col <= cnt;
        bus.wdata_col <= word_c;
      end
    end
  end

`ifdef SA_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if (state == IDLE && load_start) begin
      checksum <= '0;
    end else if (xfer) begin
      checksum <= checksum ^ word_c;
    end
  end
`endif

endmodule

// File: tb/tb_sa_sram_loader.sv
// Table-driven bench for sa_sram_loader with a write scoreboard; covers legal,
// stalled, rejected, disturbed and reset-interrupted jobs.
module tb_sa_sram_loader;
  import sa_pkg::*;

  localparam int N  = 8;
  localparam int AW = 12;
  localparam int DW = N * 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       load_start = 1'b0;
  logic       done_all = 1'b0;
  logic [7:0] k_param = '0, row_shape = '0, col_shape = '0;
  logic       start_all, busy, job_done, job_err;
`ifdef SA_LOADER_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  sa_sram_loader_if #(.N(N), .ADDR_W(AW)) bus ();

  always #5 clk = ~clk;

  sa_sram_loader #(.N(N), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_start(load_start),
    .k_param   (k_param),
    .row_shape (row_shape),
    .col_shape (col_shape),
    .bus       (bus),
    .start_all (start_all),
    .done_all  (done_all),
    .busy      (busy),
    .job_done  (job_done),
    .job_err   (job_err)
`ifdef SA_LOADER_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  typedef struct {
    int k; int row; int col; bit toggle; bit disturb; bit err; int exp_rw; int exp_cw;
  } vec_t;

  typedef struct {
    bit col; logic [AW-1:0] addr; logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int n_checks = 0, n_fail = 0;
  int cyc = 0, start_cnt = 0, done_cnt = 0, err_cnt = 0;
  int row_wr_cnt = 0, col_wr_cnt = 0, last_wr_cyc = 0, start_cyc = 0;
  int job_id = 0;
  logic [DW-1:0] xor_model = '0;
  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic check_write(input bit col, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    wr_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_write", 64'(1), 64'(0));
    end else begin
      e = exp_q.pop_front();
      check("wr_bank", 64'(col), 64'(e.col));
      check("wr_addr", 64'(addr), 64'(e.addr));
      check("wr_data", 64'(data), 64'(e.data));
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (start_all) begin start_cnt++; start_cyc = cyc; end
    if (job_done) done_cnt++;
    if (job_err) err_cnt++;
    if (bus.wen_row_n === 1'b0) begin
      row_wr_cnt++; last_wr_cyc = cyc;
      check_write(1'b0, bus.waddr_row, bus.wdata_row);
    end
    if (bus.wen_col_n === 1'b0) begin
      col_wr_cnt++; last_wr_cyc = cyc;
      check_write(1'b1, bus.waddr_col, bus.wdata_col);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] word_of(input int i);
    return (64'(job_id) << 32) | 64'(i + 1);
  endfunction

  task automatic feed(input int total, input int row_w, input bit toggle,
                      input bit disturb, input int stop_at);
    int sent = 0, guard = 0;
    bit phase = 1'b0, x;
    wr_t e;
    while (sent < total && guard < 20000) begin
      bus.in_valid = toggle ? phase : 1'b1;
      bus.in_data  = word_of(sent);
      if (disturb && sent == row_w + 2) begin
        load_start = 1'b1; done_all = 1'b1;
        k_param = 8'd7; row_shape = 8'd5; col_shape = 8'd9;
      end else begin
        load_start = 1'b0; done_all = 1'b0;
      end
      x = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (x) begin
        e.col  = (sent >= row_w);
        e.addr = AW'(e.col ? sent - row_w : sent);
        e.data = word_of(sent);
        exp_q.push_back(e);
        xor_model ^= e.data;
        sent++;
        if (stop_at > 0 && sent == stop_at) break;
      end
      phase = ~phase;
      guard++;
    end
    bus.in_valid = 1'b0; load_start = 1'b0; done_all = 1'b0;
    check("feed_count", 64'(sent), 64'(stop_at > 0 ? stop_at : total));
  endtask

  task automatic issue_start(input vec_t v);
    @(posedge clk);
    #1;
    load_start = 1'b1;
    k_param = 8'(v.k); row_shape = 8'(v.row); col_shape = 8'(v.col);
    tick();
    @(posedge clk);
    #1;
    load_start = 1'b0;
    tick();
  endtask

  task automatic run_job(input vec_t v);
    int s0, d0, e0, r0, c0, g;
    xor_model = '0;
    s0 = start_cnt; d0 = done_cnt; e0 = err_cnt; r0 = row_wr_cnt; c0 = col_wr_cnt;
    issue_start(v);
    if (v.err) begin
      check("err_busy_fin", 64'(busy), 64'(1));
      check("err_early", 64'(job_err), 64'(0));
      tick();
      check("err_at_2", 64'(job_err), 64'(1));
      check("err_busy_drop", 64'(busy), 64'(0));
      repeat (3) tick();
      check("err_writes", 64'(row_wr_cnt - r0 + col_wr_cnt - c0), 64'(0));
      check("err_start", 64'(start_cnt - s0), 64'(0));
      check("err_pulses", 64'(err_cnt - e0), 64'(1));
      check("err_done", 64'(done_cnt - d0), 64'(0));
    end else begin
      check("busy_on", 64'(busy), 64'(1));
      check("ready_on", 64'(bus.in_ready), 64'(1));
      feed(v.exp_rw + v.exp_cw, v.exp_rw, v.toggle, v.disturb, 0);
      g = 0;
      while (start_cnt == s0 && g < 50) begin tick(); g++; end
      check("start_seen", 64'(start_cnt - s0), 64'(1));
      check("start_after_wr", 64'(start_cyc > last_wr_cyc), 64'(1));
      check("ready_wait", 64'(bus.in_ready), 64'(0));
      repeat (3) tick();
      check("busy_wait", 64'(busy), 64'(1));
      check("no_early_done", 64'(done_cnt - d0), 64'(0));
      @(posedge clk);
      #1;
      done_all = 1'b1;
      @(posedge clk);
      #1;
      done_all = 1'b0;
      g = 0;
      while (job_done !== 1'b1 && g < 10) begin tick(); g++; end
      check("job_done_seen", 64'(job_done), 64'(1));
      check("busy_after", 64'(busy), 64'(0));
`ifdef SA_LOADER_CHECKSUM_EN
      check("checksum", 64'(checksum), 64'(xor_model));
`endif
      repeat (2) tick();
      check("done_pulses", 64'(done_cnt - d0), 64'(1));
      check("start_pulses", 64'(start_cnt - s0), 64'(1));
      check("err_none", 64'(err_cnt - e0), 64'(0));
      check("row_writes", 64'(row_wr_cnt - r0), 64'(v.exp_rw));
      check("col_writes", 64'(col_wr_cnt - c0), 64'(v.exp_cw));
      check("queue_empty", 64'(exp_q.size()), 64'(0));
    end
    job_id++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'(0));
    check({tag, "_wen_row"}, 64'(bus.wen_row_n), 64'(1));
    check({tag, "_wen_col"}, 64'(bus.wen_col_n), 64'(1));
    check({tag, "_waddr_row"}, 64'(bus.waddr_row), 64'(0));
    check({tag, "_waddr_col"}, 64'(bus.waddr_col), 64'(0));
    check({tag, "_wdata_row"}, 64'(bus.wdata_row), 64'(0));
    check({tag, "_wdata_col"}, 64'(bus.wdata_col), 64'(0));
    check({tag, "_start_all"}, 64'(start_all), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_job_done"}, 64'(job_done), 64'(0));
    check({tag, "_job_err"}, 64'(job_err), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, r0;
    vec_t rv;
    vecs[0] = '{2,   2,   3, 1'b0, 1'b0, 1'b0, 4,    6};
    vecs[1] = '{2,   2,   3, 1'b1, 1'b0, 1'b0, 4,    6};
    vecs[2] = '{0,   2,   3, 1'b0, 1'b0, 1'b1, 0,    0};
    vecs[3] = '{255, 255, 1, 1'b0, 1'b0, 1'b1, 0,    0};
    vecs[4] = '{1,   1,   1, 1'b0, 1'b0, 1'b0, 1,    1};
    vecs[5] = '{64,  64,  1, 1'b0, 1'b0, 1'b0, 4096, 64};
    vecs[6] = '{1,   2,   0, 1'b0, 1'b0, 1'b1, 0,    0};
    vecs[7] = '{65,  64,  1, 1'b0, 1'b0, 1'b1, 0,    0};
    vecs[8] = '{2,   2,   3, 1'b0, 1'b1, 1'b0, 4,    6};

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    #2 rst_n = 1'b0;
    #3 check_reset_outputs("por");
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 9; i++) run_job(vecs[i]);

    // Reset abandoned after the third row write, then a fresh job.
    rv = vecs[0];
    xor_model = '0;
    r0 = row_wr_cnt;
    issue_start(rv);
    feed(10, 4, 1'b0, 1'b0, 3);
    tick();
    check("rst_pre_writes", 64'(row_wr_cnt - r0), 64'(3));
    rst_n = 1'b0;
    #1 check_reset_outputs("mid");
    s0 = start_cnt; r0 = row_wr_cnt + col_wr_cnt;
    repeat (3) tick();
    check("rst_no_writes", 64'(row_wr_cnt + col_wr_cnt - r0), 64'(0));
    check("rst_no_start", 64'(start_cnt - s0), 64'(0));
    check("rst_queue", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    rst_n = 1'b1;
    repeat (2) tick();
    job_id++;
    run_job(rv);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sa_sram_loader.md
SA_SRAM_LOADER -- requirements
Module: sa_sram_loader

Interface
REQ-001 Parameter N, default 8, meaning systolic array dimension; word width is N*8 bits.
REQ-002 Parameter ADDR_W, default 12, meaning SRAM word-address width per bank.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 load_start  input  1  one-cycle request to begin a load-and-run job.
REQ-006 k_param, row_shape, col_shape  input  8 each  job shape; sampled at accepted load_start.
REQ-007 in_valid / in_ready / in_data  input / output / N*8  word stream; transfer when in_valid && in_ready.
REQ-008 wen_row_n, waddr_row, wdata_row  output  1 / ADDR_W / N*8  row-bank SRAM write port, wen active-low.
REQ-009 wen_col_n, waddr_col, wdata_col  output  1 / ADDR_W / N*8  column-bank SRAM write port, wen active-low.
REQ-010 start_all  output  1  one-cycle pulse that launches the array job.
REQ-011 done_all  input  1  one-cycle completion pulse from the array.
REQ-012 busy  output  1  high from accepted load_start until return to IDLE.
REQ-013 job_done / job_err  output  1 each  one-cycle pulse: success / rejected shape.

Function
REQ-014 FSM states: IDLE, LOAD_ROW, LOAD_COL, KICK, WAIT_ARR, FIN.
REQ-015 IDLE: load_start latches the shape; next state LOAD_ROW when row_words=row_shape*k_param and col_words=col_shape*k_param are both nonzero and both <= 2**ADDR_W, otherwise FIN with job_err.
REQ-016 Word counts use 16-bit products; no truncation before the range check.
REQ-017 in_ready is a registered output, high only in LOAD_ROW and LOAD_COL.
REQ-018 LOAD_ROW: each transfer writes one row-bank word; addresses 0..row_words-1 ascending; after the last word, go to LOAD_COL.
REQ-019 LOAD_COL: same rule on the column bank with col_words; after the last word, go to KICK.
REQ-020 Write latency: wen_*_n low, waddr_*, and wdata_* are registered and appear the cycle after the transfer; wen is high (inactive) in every other cycle.
REQ-021 in_valid low stalls the address counter; writes can have gaps.
REQ-022 KICK: start_all high for exactly one cycle, issued no earlier than one cycle after the final column write; next state WAIT_ARR.
REQ-023 WAIT_ARR: in_ready stays low; done_all moves the FSM to FIN with job_done.
REQ-024 FIN: one cycle; busy drops, then IDLE.
REQ-025 done_all outside WAIT_ARR is ignored.
REQ-026 load_start while busy is ignored; the latched shape is unchanged.
REQ-027 The address counter resets to 0 when entering each LOAD state, so no wrap occurs within a legal job.

Reset
REQ-028 rst_n low asynchronously forces IDLE with the counters at 0.
REQ-029 During reset: in_ready=0, wen_row_n=1, wen_col_n=1, waddr_*=0, wdata_*=0, start_all=0, busy=0, job_done=0, job_err=0.
REQ-030 Reset mid-job abandons the job without a further write or start_all pulse.

Configuration
REQ-031 Macro SA_LOADER_CHECKSUM_EN defined: an output checksum [N*8-1:0] carries the XOR of all words written in the current job.
REQ-032 With the macro, checksum clears at accepted load_start and is valid from job_done until the next load_start.
REQ-033 Without the macro, the checksum port and its logic are absent.

Structure
REQ-034 Shared package sa_pkg holds the state enum type, ADDR_W default, and the word-width constant.
REQ-035 One sub-module, sa_load_cnt: a clearable, enable-gated address counter with a terminal-count flag, instantiated once and reused across both LOAD states.

Verification
REQ-036 Shape k=2, row=2, col=3 with continuous valid -> 4 row writes at addr 0..3, then 6 column writes at addr 0..5, then one start_all pulse; done_all returns -> one job_done pulse.
REQ-037 Same job with in_valid toggling every other cycle -> identical addresses and data, with wen gaps matching the stalls.
REQ-038 k=0, or row_shape=255 with k=255 (65025 > 4096) -> no writes, no start_all, job_err pulses 2 cycles after load_start.
REQ-039 rst_n asserted after the 3rd row write -> all outputs take reset values immediately; a new job then starts at addr 0.
REQ-040 load_start and a spurious done_all during LOAD_COL -> both ignored; the job completes normally.
REQ-041 SA_LOADER_CHECKSUM_EN defined, words 0x01..0x0A -> checksum 0x0B at job_done.
